mc_control: RTL and testbench

- Multicycle control unit for the single-cycle ALU datapath: the driving end of the ALU control interface.
- Fetches an instruction over an imem handshake and decodes it.
- Sequences EXEC/MEM/WB and drives alu_op, alu_src and shamt to the ALU; consumes alu_zero for branch resolution.
- Sits between instruction/data memory handshakes and the register file / PC / ALU datapath.

---
 rtl/mc_pkg.sv | 85 ++++++++
 rtl/alu_op_decode.sv | 72 +++++++
 rtl/mc_control.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mc_control.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction class encoding, MIPS opcode / funct field values, ALU opcodes
// driven onto the ALU control interface, and PC source selections.
// -----------------------------------------------------------------------------
package mc_pkg;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [3:0] {
    CL_RALU = 4'd0,
    CL_IALU = 4'd1,
    CL_LW   = 4'd2,
    CL_SW   = 4'd3,
    CL_BEQ  = 4'd4,
    CL_BNE  = 4'd5,
    CL_J    = 4'd6,
    CL_JR   = 4'd7,
    CL_ILL  = 4'd8
  } iclass_e;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, IR[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU opcodes on the ALU control interface
  localparam logic [3:0] ALU_NOP   = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_ADDU  = 4'h2;
  localparam logic [3:0] ALU_SUB   = 4'h3;
  localparam logic [3:0] ALU_SUBU  = 4'h4;
  localparam logic [3:0] ALU_AND   = 4'h5;
  localparam logic [3:0] ALU_OR    = 4'h6;
  localparam logic [3:0] ALU_NOR   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLL   = 4'h9;
  localparam logic [3:0] ALU_SRL   = 4'hA;
  localparam logic [3:0] ALU_SRA   = 4'hB;
  localparam logic [3:0] ALU_PASS  = 4'hC;
  localparam logic [3:0] ALU_EQINV = 4'hD;

  // PC source selections
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b11;

  // Classes that go through the register-file writeback state
  function automatic logic cls_writes_back(input iclass_e c);
    return (c == CL_RALU) || (c == CL_IALU) || (c == CL_LW);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational instruction decoder: classifies the latched instruction
// and produces the ALU control fields for it.
// Ports:
//   opcode_i      IR[31:26]
//   funct_i       IR[5:0]
//   shamt_field_i IR[10:6]
//   iclass_o      instruction class (mc_pkg::iclass_e encoding)
//   alu_op_o      ALU opcode
//   alu_src_o     1 = immediate operand
//   ext_zero_o    1 = zero-extend immediate
//   shamt_o       shift amount
// -----------------------------------------------------------------------------
module alu_op_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] shamt_field_i,
  output logic [3:0] iclass_o,
  output logic [3:0] alu_op_o,
  output logic       alu_src_o,
  output logic       ext_zero_o,
  output logic [4:0] shamt_o
);

  iclass_e cls_s;

  // Opcode / funct classification and ALU field selection
  always_comb begin
    cls_s      = CL_ILL;
    alu_op_o   = ALU_NOP;
    alu_src_o  = 1'b0;
    ext_zero_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  begin cls_s = CL_RALU; alu_op_o = ALU_ADD;  end
          FN_ADDU: begin cls_s = CL_RALU; alu_op_o = ALU_ADDU; end
          FN_SUB:  begin cls_s = CL_RALU; alu_op_o = ALU_SUB;  end
          FN_SUBU: begin cls_s = CL_RALU; alu_op_o = ALU_SUBU; end
          FN_AND:  begin cls_s = CL_RALU; alu_op_o = ALU_AND;  end
          FN_OR:   begin cls_s = CL_RALU; alu_op_o = ALU_OR;   end
          FN_NOR:  begin cls_s = CL_RALU; alu_op_o = ALU_NOR;  end
          FN_SLT:  begin cls_s = CL_RALU; alu_op_o = ALU_SLT;  end
          FN_SLL:  begin cls_s = CL_RALU; alu_op_o = ALU_SLL;  end
          FN_SRL:  begin cls_s = CL_RALU; alu_op_o = ALU_SRL;  end
          FN_SRA:  begin cls_s = CL_RALU; alu_op_o = ALU_SRA;  end
          FN_JR:   begin cls_s = CL_JR;   alu_op_o = ALU_PASS; end
          default: begin cls_s = CL_ILL;  alu_op_o = ALU_NOP;  end
        endcase
      end
      OP_ADDI:  begin cls_s = CL_IALU; alu_op_o = ALU_ADD;  alu_src_o = 1'b1; end
      OP_ADDIU: begin cls_s = CL_IALU; alu_op_o = ALU_ADDU; alu_src_o = 1'b1; end
      OP_ANDI:  begin cls_s = CL_IALU; alu_op_o = ALU_AND;  alu_src_o = 1'b1; ext_zero_o = 1'b1; end
      OP_ORI:   begin cls_s = CL_IALU; alu_op_o = ALU_OR;   alu_src_o = 1'b1; ext_zero_o = 1'b1; end
      OP_LW:    begin cls_s = CL_LW;   alu_op_o = ALU_ADD;  alu_src_o = 1'b1; end
      OP_SW:    begin cls_s = CL_SW;   alu_op_o = ALU_ADD;  alu_src_o = 1'b1; end
      // Branch compare: beq subtracts, bne uses the inverted-equality op so
      // that alu_zero means "take the branch" for both.
      OP_BEQ:   begin cls_s = CL_BEQ;  alu_op_o = ALU_SUB;   end
      OP_BNE:   begin cls_s = CL_BNE;  alu_op_o = ALU_EQINV; end
      OP_J:     begin cls_s = CL_J;    alu_op_o = ALU_NOP;   end
      default:  begin cls_s = CL_ILL;  alu_op_o = ALU_NOP;   end
    endcase
  end

  assign iclass_o = cls_s;
  assign shamt_o  = shamt_field_i;

endmodule

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multicycle control unit for the single-cycle ALU datapath. Fetches an
// instruction over the imem handshake, decodes it, and sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), driving the ALU control interface
// (alu_op / alu_src / ext_zero / shamt) and the datapath strobes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_ready/instr instruction fetch handshake
//   alu_zero                 ALU Zero flag (branch resolution in EXEC)
//   alu_op/alu_src/ext_zero/shamt  ALU control, held from EXEC through WB
//   ir_write                 latch instr into datapath IR (fetch cycle)
//   reg_write/reg_dst/mem_to_reg   register file writeback controls (WB)
//   mem_req/mem_we/mem_ready data memory handshake (MEM)
//   pc_write/pc_src          PC update strobe and source select
//   illegal                  sticky illegal-instruction flag
//
// Build option: define ILLEGAL_TRAP_EN to trap on unrecognised instructions
// (TRAP state, illegal=1 until rst). Without it they execute as a NOP and
// illegal is tied low.
//
// All outputs are registered from the next state except ir_write and
// pc_write, which must respond to imem_ready / alu_zero in the same cycle.
// -----------------------------------------------------------------------------
module mc_control
  import mc_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        ext_zero,
  output logic [4:0]  shamt,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        illegal
);

  // No PC is held here: the datapath forms the PC_W-bit branch/jump/ALU
  // target selected by pc_src. The parameter only documents that width.
  if (PC_W < 2) begin : g_pc_w_note
  end

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic        imem_req_q, imem_req_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        alu_src_q, alu_src_d;
  logic        ext_zero_q, ext_zero_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        reg_write_q, reg_write_d;
  logic        reg_dst_q, reg_dst_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  pc_src_q, pc_src_d;

  logic [3:0]  cls_raw_s;
  iclass_e     cls_s;
  logic [3:0]  dec_alu_op_s;
  logic        dec_alu_src_s;
  logic        dec_ext_zero_s;
  logic [4:0]  dec_shamt_s;
  logic        fetch_take_s;
  logic        alu_hold_s;
  logic        unused_ir_s;

  alu_op_decode u_dec (
    .opcode_i      (ir_q[31:26]),
    .funct_i       (ir_q[5:0]),
    .shamt_field_i (ir_q[10:6]),
    .iclass_o      (cls_raw_s),
    .alu_op_o      (dec_alu_op_s),
    .alu_src_o     (dec_alu_src_s),
    .ext_zero_o    (dec_ext_zero_s),
    .shamt_o       (dec_shamt_s)
  );

  assign cls_s = iclass_e'(cls_raw_s);

  // Register/immediate fields are consumed by the datapath's own IR copy.
  assign unused_ir_s = ^ir_q[25:11];

  // A fetch completes only while our request is actually up.
  assign fetch_take_s = (state_q == ST_FETCH) && imem_req_q && imem_ready;

  // Next-state and internal IR update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_take_s) begin
          state_d = ST_DECODE;
          ir_d    = instr;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (cls_s == CL_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_s)
          CL_RALU, CL_IALU: state_d = ST_WB;
          CL_LW, CL_SW:     state_d = ST_MEM;
          default:          state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = cls_writes_back(cls_s) ? ST_WB : ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = ST_TRAP;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Moore output values for the state being entered
  always_comb begin
    alu_hold_s   = (state_d == ST_EXEC) || (state_d == ST_MEM) || (state_d == ST_WB);
    imem_req_d   = (state_d == ST_FETCH);
    if (alu_hold_s) begin
      alu_op_d   = dec_alu_op_s;
      alu_src_d  = dec_alu_src_s;
      ext_zero_d = dec_ext_zero_s;
      shamt_d    = dec_shamt_s;
    end else begin
      alu_op_d   = ALU_NOP;
      alu_src_d  = 1'b0;
      ext_zero_d = 1'b0;
      shamt_d    = 5'd0;
    end
    if (state_d == ST_EXEC) begin
      case (cls_s)
        CL_BEQ, CL_BNE: pc_src_d = PC_BRANCH;
        CL_J:           pc_src_d = PC_JUMP;
        CL_JR:          pc_src_d = PC_ALU;
        default:        pc_src_d = PC_SEQ;
      endcase
    end else begin
      pc_src_d = PC_SEQ;
    end
    mem_req_d    = (state_d == ST_MEM);
    mem_we_d     = (state_d == ST_MEM) && (cls_s == CL_SW);
    reg_write_d  = (state_d == ST_WB);
    reg_dst_d    = (state_d == ST_WB) && (cls_s == CL_RALU);
    mem_to_reg_d = (state_d == ST_WB) && (cls_s == CL_LW);
  end

  // PC strobe: fetch completion, or EXEC for branches (alu_zero) and jumps
  always_comb begin
    pc_write = 1'b0;
    if (rst) begin
      pc_write = 1'b0;
    end else if (state_q == ST_FETCH) begin
      pc_write = fetch_take_s;
    end else if (state_q == ST_EXEC) begin
      case (cls_s)
        CL_BEQ, CL_BNE: pc_write = alu_zero;
        CL_J, CL_JR:    pc_write = 1'b1;
        default:        pc_write = 1'b0;
      endcase
    end else begin
      pc_write = 1'b0;
    end
  end

  assign ir_write = fetch_take_s && !rst;

  // State, IR and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      ir_q         <= 32'd0;
      imem_req_q   <= 1'b0;
      alu_op_q     <= ALU_NOP;
      alu_src_q    <= 1'b0;
      ext_zero_q   <= 1'b0;
      shamt_q      <= 5'd0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      pc_src_q     <= PC_SEQ;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      ext_zero_q   <= ext_zero_d;
      shamt_q      <= shamt_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      pc_src_q     <= pc_src_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (state_d == ST_TRAP);
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign imem_req   = imem_req_q;
  assign alu_op     = alu_op_q;
  assign alu_src    = alu_src_q;
  assign ext_zero   = ext_zero_q;
  assign shamt      = shamt_q;
  assign reg_write  = reg_write_q;
  assign reg_dst    = reg_dst_q;
  assign mem_to_reg = mem_to_reg_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign pc_src     = pc_src_q;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
// Self-checking bench for mc_control: a table of instructions with their
// expected ALU opcode, shift amount and latency, hand-written multicycle
// sequences (memory waits, branches, reset mid-access, illegal opcode), and
// randomized instruction streams checked cycle by cycle against an
// instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_mc_control;

  logic        clk, rst;
  logic        imem_req, imem_ready;
  logic [31:0] instr;
  logic        alu_zero;
  logic [3:0]  alu_op;
  logic        alu_src, ext_zero;
  logic [4:0]  shamt;
  logic        ir_write, reg_write, reg_dst, mem_to_reg;
  logic        mem_req, mem_we, mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal;

  mc_control #(.PC_W(10)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
    .alu_zero(alu_zero),
    .alu_op(alu_op), .alu_src(alu_src), .ext_zero(ext_zero), .shamt(shamt),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       ext_zero;
    logic [4:0] shamt;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    int          exp_len;
    logic [3:0]  exp_op;
    logic [4:0]  exp_sh;
  } vec_t;

  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3,
                 K_BR = 4, K_J = 5, K_JR = 6, K_ILL = 7;

  int n_vec = 0;
  int n_bad = 0;

  logic [5:0] r_fn   [11];
  logic [5:0] i_opc  [4];
  logic [3:0] i_aluop[4];
  vec_t       tbl    [12];

  // Instruction-level reference: what the ISA says each word means
  function automatic void model(input logic [31:0] w, output int kind,
                                output logic [3:0] op, output logic src, output logic ez);
    logic [5:0] opc, fn;
    opc = w[31:26]; fn = w[5:0];
    kind = K_ILL; op = 4'h0; src = 1'b0; ez = 1'b0;
    if (opc == 6'h00) begin
      for (int i = 0; i < 11; i++) if (fn == r_fn[i]) begin kind = K_RALU; op = 4'(i + 1); end
      if (fn == 6'h08) begin kind = K_JR; op = 4'hC; end
    end else begin
      for (int i = 0; i < 4; i++)
        if (opc == i_opc[i]) begin kind = K_IALU; op = i_aluop[i]; src = 1'b1; ez = (i >= 2); end
      if (opc == 6'h23) begin kind = K_LW; op = 4'h1; src = 1'b1; end
      if (opc == 6'h2B) begin kind = K_SW; op = 4'h1; src = 1'b1; end
      if (opc == 6'h04) begin kind = K_BR; op = 4'h3; end
      if (opc == 6'h05) begin kind = K_BR; op = 4'hD; end
      if (opc == 6'h02) begin kind = K_J;  op = 4'h0; end
    end
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.imem_req = imem_req; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_src = pc_src; o.alu_op = alu_op; o.alu_src = alu_src;
    o.ext_zero = ext_zero; o.shamt = shamt; o.reg_write = reg_write;
    o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg; o.mem_req = mem_req;
    o.mem_we = mem_we; o.illegal = illegal;
    return o;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 with inputs already set; samples at the falling edge
  task automatic check(input string name, input obs_t e);
    obs_t a;
    #4;
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
    end
    step();
  endtask

  task automatic do_reset();
    obs_t e;
    rst = 1'b1; imem_ready = 1'b1; mem_ready = 1'b1; instr = 32'h00221820;
    step();
    step();
    // First cycle after reset: no request yet, so imem_ready must be ignored
    rst = 1'b0; imem_ready = 1'b1; e = '0;
    check("post_reset", e);
  endtask

  // Drive one instruction through the handshakes, checking every cycle
  task automatic run_instr(input logic [31:0] w, input int iw, input int mw, input logic z);
    int kind; logic [3:0] op; logic src, ez;
    obs_t e, a;
    model(w, kind, op, src, ez);
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0; instr = $urandom; alu_zero = 1'($urandom); mem_ready = 1'($urandom);
      e = '0; e.imem_req = 1'b1;
      check("fetch_wait", e);
    end
    imem_ready = 1'b1; instr = w;
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    check("fetch", e);
    imem_ready = 1'($urandom); instr = $urandom;
    e = '0;
    check("decode", e);
    if (kind == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
        imem_ready = 1'($urandom); mem_ready = 1'($urandom); alu_zero = 1'($urandom);
        e = '0; e.illegal = 1'b1;
        check("trap", e);
      end
`endif
      return;
    end
    a = '0; a.alu_op = op; a.alu_src = src; a.ext_zero = ez; a.shamt = w[10:6];
    alu_zero = z; imem_ready = 1'($urandom); mem_ready = 1'($urandom);
    e = a;
    if (kind == K_BR) begin e.pc_src = 2'b01; e.pc_write = z; end
    if (kind == K_J)  begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
    if (kind == K_JR) begin e.pc_src = 2'b11; e.pc_write = 1'b1; end
    check("exec", e);
    if (kind == K_LW || kind == K_SW) begin
      e = a; e.mem_req = 1'b1; e.mem_we = (kind == K_SW);
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0; alu_zero = 1'($urandom);
        check("mem_wait", e);
      end
      mem_ready = 1'b1;
      check("mem", e);
    end
    if (kind == K_RALU || kind == K_IALU || kind == K_LW) begin
      mem_ready = 1'($urandom); alu_zero = 1'($urandom);
      e = a; e.reg_write = 1'b1; e.reg_dst = (kind == K_RALU); e.mem_to_reg = (kind == K_LW);
      check("wb", e);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {6'h00, r[25:6], r_fn[$urandom_range(0, 10)]};
      1: return {6'h00, r[25:6], 6'h08};
      2: return {i_opc[$urandom_range(0, 3)], r[25:0]};
      3: return {6'h23, r[25:0]};
      4: return {6'h2B, r[25:0]};
      5: return {6'h04, r[25:0]};
      6: return {6'h05, r[25:0]};
      7: return {6'h02, r[25:0]};
      8: return r;
      default: return {6'h00, r[25:0]};
    endcase
  endfunction

  initial begin
    obs_t e;
    int len, kind;
    logic [3:0] got_op, op;
    logic [4:0] got_sh;
    logic done, src, ez;
    logic [31:0] w;

    r_fn    = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
    i_opc   = '{6'h08, 6'h09, 6'h0C, 6'h0D};
    i_aluop = '{4'h1, 4'h2, 4'h5, 4'h6};
    tbl[0]  = '{32'h00221820, 4, 4'h1, 5'd0};  // add
    tbl[1]  = '{32'h00021940, 4, 4'h9, 5'd5};  // sll $3,$2,5
    tbl[2]  = '{32'h00221822, 4, 4'h3, 5'd0};  // sub
    tbl[3]  = '{32'h000219C3, 4, 4'hB, 5'd7};  // sra $3,$2,7
    tbl[4]  = '{32'h0022182A, 4, 4'h8, 5'd0};  // slt
    tbl[5]  = '{32'h34220005, 4, 4'h6, 5'd0};  // ori
    tbl[6]  = '{32'h30220005, 4, 4'h5, 5'd0};  // andi
    tbl[7]  = '{32'h8C220004, 5, 4'h1, 5'd0};  // lw
    tbl[8]  = '{32'hAC220004, 4, 4'h1, 5'd0};  // sw
    tbl[9]  = '{32'h10220003, 3, 4'h3, 5'd0};  // beq
    tbl[10] = '{32'h14220003, 3, 4'hD, 5'd0};  // bne
    tbl[11] = '{32'h00200008, 3, 4'hC, 5'd0};  // jr

    rst = 1'b1; imem_ready = 1'b0; instr = 32'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // Table: latency (fetch-ready cycle until imem_req returns), EXEC alu_op/shamt
    for (int t = 0; t < 12; t++) begin
      instr = tbl[t].instr; imem_ready = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0;
      len = 0; got_op = 4'h0; got_sh = 5'd0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        #4;
        if (c == 2) begin got_op = alu_op; got_sh = shamt; end
        if (c > 0 && imem_req) done = 1'b1; else len++;
        step();
        imem_ready = 1'b0;
      end
      n_vec += 3;
      if (!done) begin
        n_bad++; $display("FAIL tbl_timeout[%0d]: got no refetch expected refetch", t);
      end else if (len != tbl[t].exp_len) begin
        n_bad++; $display("FAIL tbl_len[%0d]: got %0d expected %0d", t, len, tbl[t].exp_len);
      end
      if (got_op !== tbl[t].exp_op) begin
        n_bad++; $display("FAIL tbl_op[%0d]: got %h expected %h", t, got_op, tbl[t].exp_op);
      end
      if (got_sh !== tbl[t].exp_sh) begin
        n_bad++; $display("FAIL tbl_shamt[%0d]: got %0d expected %0d", t, got_sh, tbl[t].exp_sh);
      end
      if (!done) do_reset();
    end
    mem_ready = 1'b0;

    // Memory waits, branch resolution both ways, jump
    run_instr(32'h8C220004, 0, 3, 1'b0);
    run_instr(32'hAC220004, 1, 3, 1'b0);
    run_instr(32'h10220003, 0, 0, 1'b1);
    run_instr(32'h10220003, 0, 0, 1'b0);
    run_instr(32'h14220003, 2, 0, 1'b1);
    run_instr(32'h14220003, 0, 0, 1'b0);
    run_instr(32'h08000010, 0, 0, 1'b0);

    // Reset during a MEM wait, with mem_ready arriving on the reset edge
    model(32'h8C220004, kind, op, src, ez);
    imem_ready = 1'b1; instr = 32'h8C220004;
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    check("rm_fetch", e);
    imem_ready = 1'b0; e = '0;
    check("rm_decode", e);
    e = '0; e.alu_op = op; e.alu_src = src;
    check("rm_exec", e);
    mem_ready = 1'b0; e.mem_req = 1'b1;
    check("rm_mem_wait", e);
    rst = 1'b1; mem_ready = 1'b1; imem_ready = 1'b1;
    step();
    rst = 1'b0; e = '0;
    check("rm_after_rst", e);
    run_instr(32'h00221820, 0, 0, 1'b0);

    // Unrecognised opcode
    run_instr(32'hFC000000, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif
    run_instr(32'h00221820, 0, 0, 1'b0);

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      w = rand_instr();
`ifdef ILLEGAL_TRAP_EN
      model(w, kind, op, src, ez);
      if (kind == K_ILL) w = 32'h00221820;
`endif
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
